// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, start/busy/done
// handshake, full 2*WIDTH-bit product held in a register until the next completion.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N);
    localparam int EW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    state_t          state_next;
    logic [EW-1:0]   mreg;
    logic [EW-1:0]   qreg;
    logic            qm1;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   mext;
    logic [AW-1:0]   term;
    logic [AW-1:0]   acc_next;
    logic            last;

    // Two extra operand bits let unsigned values ride through signed Booth recoding.
    always_comb begin
        mext = {{(AW - EW){mreg[EW-1]}}, mreg};
        term = '0;
        case ({qreg[1:0], qm1})
            3'b001, 3'b010: term = mext;
            3'b011:         term = mext << 1;
            3'b100:         term = -(mext << 1);
            3'b101, 3'b110: term = -mext;
            default:        term = '0;
        endcase
        acc_next = acc + (term << {cnt, 1'b0});
        last     = (cnt == CW'(N - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreg    <= '0;
            qreg    <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mreg <= {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
                        qreg <= {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};
                        qm1  <= 1'b0;
                        cnt  <= '0;
                        acc  <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    qm1  <= qreg[1];
                    qreg <= {qreg[EW-1], qreg[EW-1], qreg[EW-1:2]};
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        product <= acc_next[2*WIDTH-1:0];
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: 32-bit vectors, handshake, reset mid-run,
// and an 8-bit operand grid checked against an integer reference.
module tb_booth_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;

    logic        start8;
    logic        signed_mode8;
    logic [7:0]  multiplicand8;
    logic [7:0]  multiplier8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    int checks = 0;
    int errors = 0;

    logic [7:0] vals [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80, 8'h81, 8'hFE,
                              8'hFF, 8'h55, 8'hAA, 8'h0F, 8'h40, 8'h7E, 8'hC3, 8'h99};

    booth_mul_seq #(.WIDTH(32)) dut32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    booth_mul_seq #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start8),
        .signed_mode  (signed_mode8),
        .multiplicand (multiplicand8),
        .multiplier   (multiplier8),
        .busy         (busy8),
        .done         (done8),
        .product      (product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Launch one 32-bit multiply and wait (bounded) for done.
    task automatic applyStimulus(input logic sm, input logic [31:0] m, input logic [31:0] q,
                                 output int lat, output int busyCnt,
                                 output logic [63:0] prod);
        @(negedge clk);
        signed_mode  = sm;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        busyCnt = busy ? 1 : 0;
        lat     = 0;
        prod    = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (busy) busyCnt++;
            if (done) begin
                lat  = k;
                prod = product;
                break;
            end
        end
    endtask

    task automatic applyStimulus8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                                  output int lat, output logic [15:0] prod);
        @(negedge clk);
        signed_mode8  = sm;
        multiplicand8 = m;
        multiplier8   = q;
        start8        = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat    = 0;
        prod   = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                lat  = k;
                prod = product8;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          busyCnt;
        int          doneCnt;
        int          holdErr;
        int          ia;
        int          ib;
        logic [63:0] prod;
        logic [15:0] prod8;
        logic [15:0] exp8;

        rst_n         = 1'b1;
        start         = 1'b0;
        signed_mode   = 1'b0;
        multiplicand  = '0;
        multiplier    = '0;
        start8        = 1'b0;
        signed_mode8  = 1'b0;
        multiplicand8 = '0;
        multiplier8   = '0;
        #1;
        rst_n = 1'b0;
        #2;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_product", product, 64'd0);
        checkOutput("reset_product8", 64'(product8), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 32'd3, 32'd5, lat, busyCnt, prod);
        checkOutput("s_3x5_latency", 64'(lat), 64'd17);
        checkOutput("s_3x5_busycycles", 64'(busyCnt), 64'd17);
        checkOutput("s_3x5_product", prod, 64'h0000_0000_0000_000F);

        applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, lat, busyCnt, prod);
        checkOutput("s_minxmin", prod, 64'h4000_0000_0000_0000);

        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, lat, busyCnt, prod);
        checkOutput("s_m1x2", prod, 64'hFFFF_FFFF_FFFF_FFFE);

        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busyCnt, prod);
        checkOutput("u_maxxmax", prod, 64'hFFFF_FFFE_0000_0001);

        applyStimulus(1'b0, 32'h8000_0000, 32'h0000_0002, lat, busyCnt, prod);
        checkOutput("u_msbx2", prod, 64'h0000_0001_0000_0000);

        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, lat, busyCnt, prod);
        checkOutput("u_maxxmsb", prod, 64'h7FFF_FFFF_8000_0000);

        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, lat, busyCnt, prod);
        checkOutput("s_m1xmin", prod, 64'h0000_0000_8000_0000);

        // Handshake: a start pulse mid-run must be ignored.
        @(negedge clk);
        signed_mode  = 1'b1;
        multiplicand = 32'd100;
        multiplier   = 32'hFFFF_FFFD;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 0;
        doneCnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) begin
                multiplicand = 32'h1234_5678;
                multiplier   = 32'h0000_0FFF;
                signed_mode  = 1'b0;
                start        = 1'b1;
            end
            if (k == 5) start = 1'b0;
            if (done) begin
                doneCnt++;
                lat = k;
                break;
            end
        end
        checkOutput("hs_first_latency", 64'(lat), 64'd17);
        checkOutput("hs_first_product", product, 64'hFFFF_FFFF_FFFF_FED4);

        // Start in the done cycle is accepted; old product holds until new done.
        signed_mode  = 1'b0;
        multiplicand = 32'h0000_0010;
        multiplier   = 32'h0000_0020;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("hs_done_drops", 64'(done), 64'd0);
        checkOutput("hs_second_accepted", 64'(busy), 64'd1);
        lat     = 0;
        holdErr = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (product !== 64'hFFFF_FFFF_FFFF_FED4) holdErr++;
        end
        checkOutput("hs_extra_done", 64'(doneCnt), 64'd1);
        checkOutput("hs_product_hold", 64'(holdErr), 64'd0);
        checkOutput("hs_second_latency", 64'(lat), 64'd17);
        checkOutput("hs_second_product", product, 64'h0000_0000_0000_0200);

        // Reset in the middle of a multiply.
        @(negedge clk);
        signed_mode  = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd11;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_done", 64'(done), 64'd0);
        checkOutput("rst_mid_product", product, 64'd0);
        doneCnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) doneCnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) doneCnt++;
        end
        checkOutput("rst_mid_nodone", 64'(doneCnt), 64'd0);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFA, lat, busyCnt, prod);
        checkOutput("rst_after_latency", 64'(lat), 64'd17);
        checkOutput("rst_after_product", prod, 64'hFFFF_FFFF_FFFF_FFD6);

        // WIDTH=8 operand grid, both modes.
        for (int mode = 0; mode < 2; mode++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    if (mode == 1) begin
                        ia = $signed(vals[i]);
                        ib = $signed(vals[j]);
                    end else begin
                        ia = int'(vals[i]);
                        ib = int'(vals[j]);
                    end
                    exp8 = 16'(ia * ib);
                    applyStimulus8(mode[0], vals[i], vals[j], lat, prod8);
                    checkOutput($sformatf("w8_lat_%0d_%h_%h", mode, vals[i], vals[j]),
                                64'(lat), 64'd5);
                    checkOutput($sformatf("w8_prod_%0d_%h_%h", mode, vals[i], vals[j]),
                                64'(prod8), 64'(exp8));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
